// File: rtl/i2s_rx_pkg.sv
// Shared definitions for the I2S microphone receiver.
//   state_t    : receiver FSM states
//   FRAME_LEN  : SCK cycles per frame at the default slot width
//   frame_len  : SCK cycles per frame for a given slot width
//   cnt_width  : bit width of the in-frame cycle counter
package i2s_rx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STARTUP = 2'd1,
      RUN     = 2'd2
   } state_t;

   localparam int SLOT_W_DEFAULT = 32;

   function automatic int frame_len(input int slot_w);
      return 2 * slot_w;
   endfunction

   function automatic int cnt_width(input int slot_w);
      return $clog2(frame_len(slot_w));
   endfunction

   localparam int FRAME_LEN = frame_len(SLOT_W_DEFAULT);

endpackage

// File: rtl/i2s_lane_deser.sv
// One I2S data line: deserialises the left and right words carried on a
// single sd line and presents them as a published sample pair.
//   clk, rst_n    : audio clock, synchronous active-low reset
//   sd            : serial data bit for this line
//   shift_en      : shift sd into the LSB of the shift register
//   hold_left     : snapshot the shift register as the left word
//   publish       : move left hold + right shift register to the outputs
//   sample_left   : published left word (raw two's complement)
//   sample_right  : published right word (raw two's complement)
module i2s_lane_deser #(
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sd,
   input  logic              shift_en,
   input  logic              hold_left,
   input  logic              publish,
   output logic [DATA_W-1:0] sample_left,
   output logic [DATA_W-1:0] sample_right
);

   logic signed [DATA_W-1:0] shift_p0;
   logic signed [DATA_W-1:0] hold_p1;
   logic signed [DATA_W-1:0] left_p2;
   logic signed [DATA_W-1:0] right_p2;

   // Stage 0/1: serial capture, then left-word snapshot. Every word fully
   // overwrites the shift register, so these need no reset.
   always_ff @(posedge clk) begin
      if (shift_en) begin
         shift_p0 <= DATA_W'({shift_p0, sd});
      end
      if (hold_left) begin
         hold_p1 <= shift_p0;
      end
   end

   // Stage 2: published sample pair, held until the next publish.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         left_p2  <= '0;
         right_p2 <= '0;
      end else if (publish) begin
         left_p2  <= hold_p1;
         right_p2 <= shift_p0;
      end
   end

   assign sample_left  = left_p2;
   assign sample_right = right_p2;

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for an array of MEMS microphones. Generates word
// select, gates the forwarded SCK, discards frames while the mics power up,
// then deserialises NUM_LINES stereo lines and offers each frame on a
// valid/ready handshake with a sticky overrun flag.
//   clk, rst_n     : 3.072 MHz audio clock, synchronous active-low reset
//   pll_locked     : PLL lock flag (asynchronous, synchronised here)
//   enable         : software run enable
//   sd             : serial data, one bit per line
//   sck_en         : SCK forwarding enable
//   ws             : word select, 0 = left slot, 1 = right slot
//   sample_left    : left samples, line i at [i*DATA_W +: DATA_W]
//   sample_right   : right samples, same packing
//   sample_valid   : frame available
//   sample_ready   : consumer accepts the frame
//   overrun        : sticky, an unaccepted frame was overwritten
//   overrun_clr    : clears overrun (a simultaneous set wins)
module i2s_mic_rx
   import i2s_rx_pkg::*;
#(
   parameter int NUM_LINES      = 4,
   parameter int DATA_W         = 24,
   parameter int SLOT_W         = 32,
   parameter int STARTUP_FRAMES = 512
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          pll_locked,
   input  logic                          enable,
   input  logic [NUM_LINES-1:0]          sd,
   output logic                          sck_en,
   output logic                          ws,
   output logic [NUM_LINES*DATA_W-1:0]   sample_left,
   output logic [NUM_LINES*DATA_W-1:0]   sample_right,
   output logic                          sample_valid,
   input  logic                          sample_ready,
   output logic                          overrun,
   input  logic                          overrun_clr
);

   localparam int CNT_W = cnt_width(SLOT_W);
   localparam int FC_W  = $clog2(STARTUP_FRAMES + 1);

   localparam logic [CNT_W-1:0] SLOT_C     = CNT_W'(SLOT_W);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_W - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(frame_len(SLOT_W) - 1);
   localparam logic [CNT_W-1:0] DATA_C     = CNT_W'(DATA_W);
   localparam logic [FC_W-1:0]  START_LAST = FC_W'(STARTUP_FRAMES - 1);

   logic              lock_meta;
   logic              lock_s;
   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [CNT_W-1:0]  cnt_inc;
   logic [CNT_W-1:0]  k;
   logic [FC_W-1:0]   frame_cnt;
   logic [FC_W-1:0]   frame_nxt;
   logic              active;
   logic              wrap;
   logic              shift_en;
   logic              hold_left;
   logic              publish;

   logic [DATA_W-1:0] lane_left  [NUM_LINES];
   logic [DATA_W-1:0] lane_right [NUM_LINES];

   // Lock synchroniser: two flops before the FSM sees pll_locked.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;
      end
   end

   assign active  = lock_s && enable;
   assign wrap    = (cnt == FRAME_LAST);
   assign cnt_inc = wrap ? '0 : cnt + 1'b1;
   assign k       = (cnt >= SLOT_C) ? cnt - SLOT_C : cnt;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      frame_nxt = frame_cnt;
      shift_en  = 1'b0;
      hold_left = 1'b0;
      publish   = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt   = '0;
            frame_nxt = '0;
            if (active) begin
               state_nxt = STARTUP;
            end
         end
         STARTUP: begin
            if (!active) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               frame_nxt = '0;
            end else begin
               cnt_nxt = cnt_inc;
               if (wrap) begin
                  if (frame_cnt == START_LAST) begin
                     state_nxt = RUN;
                     frame_nxt = '0;
                  end else begin
                     frame_nxt = frame_cnt + 1'b1;
                  end
               end
            end
         end
         RUN: begin
            if (!active) begin
               // Abort drops the in-flight frame; published data is kept.
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt_inc;
               // One-bit I2S delay: the MSB arrives at k=1.
               shift_en  = (k != '0) && (k <= DATA_C);
               hold_left = (cnt == SLOT_LAST);
               publish   = wrap;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            frame_nxt = '0;
         end
      endcase
   end

   // Registered state, counter and pad outputs; ws and sck_en are
   // derived from next values so they align with cnt and stay glitch-free.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         frame_cnt <= '0;
         ws        <= 1'b0;
         sck_en    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         frame_cnt <= frame_nxt;
         ws        <= (cnt_nxt >= SLOT_C);
         sck_en    <= (state_nxt != IDLE);
      end
   end

   // Handshake: a publish always wins over a same-edge transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (publish) begin
            sample_valid <= 1'b1;
         end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
         end
         if (publish && sample_valid && !sample_ready) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

   for (genvar g = 0; g < NUM_LINES; g++) begin : g_lane
      i2s_lane_deser #(
         .DATA_W (DATA_W)
      ) u_lane (
         .clk          (clk),
         .rst_n        (rst_n),
         .sd           (sd[g]),
         .shift_en     (shift_en),
         .hold_left    (hold_left),
         .publish      (publish),
         .sample_left  (lane_left[g]),
         .sample_right (lane_right[g])
      );
   end

   always_comb begin
      sample_left  = '0;
      sample_right = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         sample_left[i*DATA_W +: DATA_W]  = lane_left[i];
         sample_right[i*DATA_W +: DATA_W] = lane_right[i];
      end
   end

endmodule
